// File: rtl/break_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sat_pkg
// Description : Shared types and helpers for the WalkSAT break-value scan
//               controller (state encoding, width helpers, all-ones value).
// Revision    : 1.0 - initial release
// ============================================================================
package sat_pkg;

  // Scan sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIND = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Break-value width: must hold every value 0..n (all clauses broken)
  function automatic int bv_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Slot index width, never narrower than one bit
  function automatic int lit_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Wide all-ones pattern, sliced down to the break-value width by users
  localparam logic [31:0] c_bv_all_ones = 32'hFFFF_FFFF;

endpackage : sat_pkg
`default_nettype wire

// File: rtl/break_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : break_scan_controller_if
// Description : Request/response channel between the break-scan controller
//               (master) and the clause evaluators (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface break_scan_controller_if
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES = 20,
  parameter int NUM_LITS    = 3
);
  localparam int LIT_W = lit_width(NUM_LITS);

  logic                   eval_req_o;
  logic [LIT_W-1:0]       eval_lit_o;
  logic                   eval_valid_i;
  logic [NUM_CLAUSES-1:0] clause_broken_i;
  logic [NUM_CLAUSES-1:0] mask_bits_i;

  modport master (
    output eval_req_o, eval_lit_o,
    input  eval_valid_i, clause_broken_i, mask_bits_i
  );

  modport slave (
    input  eval_req_o, eval_lit_o,
    output eval_valid_i, clause_broken_i, mask_bits_i
  );
endinterface : break_scan_controller_if
`default_nettype wire

// File: rtl/break_scan_controller_popcount.sv
`default_nettype none
// ============================================================================
// Module      : break_popcount
// Description : Combinational masked popcount of the clause-broken vector.
//               Output width holds the all-broken count without wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module break_popcount #(
  parameter int NUM_CLAUSES = 20,
  parameter int BV_W        = 5
) (
  input  wire logic [NUM_CLAUSES-1:0] i_broken,
  input  wire logic [NUM_CLAUSES-1:0] i_mask,
  output logic      [BV_W-1:0]        o_count
);

  // Count clauses that are both broken and present in the clause table
  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      o_count = o_count + BV_W'(i_broken[i] & i_mask[i]);
    end
  end

endmodule : break_popcount
`default_nettype wire

// File: rtl/break_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : break_scan_controller
// Description : Walks the valid literal slots of one unsatisfied clause,
//               requests each slot's broken vector, and keeps the slot with
//               the minimum masked break value (ties keep the lower index).
//               Optional macro FREEBIE_EXIT_EN: finish the scan as soon as a
//               slot with zero break value is found.
// Revision    : 1.0 - initial release
// ============================================================================
module break_scan_controller
  import sat_pkg::*;
#(
  parameter  int NUM_CLAUSES = 20,
  parameter  int NUM_LITS    = 3,
  localparam int LIT_W       = lit_width(NUM_LITS),
  localparam int BV_W        = bv_width(NUM_CLAUSES)
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                start_i,
  input  wire logic                abort_i,
  input  wire logic [NUM_LITS-1:0] cand_valid_i,
  break_scan_controller_if.master  eval_if,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     sel_valid_o,
  output logic [LIT_W-1:0]         sel_lit_o,
  output logic [BV_W-1:0]          sel_break_o
);

  localparam logic [BV_W-1:0] c_bv_ones = c_bv_all_ones[BV_W-1:0];

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_LITS-1:0]  r_pend;
  logic [LIT_W-1:0]     r_eval_lit;
  logic [BV_W-1:0]      r_best_bv;
  logic [LIT_W-1:0]     r_best_lit;
  logic                 r_best_valid;
  logic [BV_W-1:0]      r_sel_bv;
  logic [LIT_W-1:0]     r_sel_lit;
  logic                 r_sel_valid;

  logic [BV_W-1:0]      w_bv;
  logic                 w_hs;
  logic                 w_better;
  logic                 w_freebie;
  logic [LIT_W-1:0]     w_first_lit;
  logic [NUM_LITS-1:0]  w_lit_onehot;
  logic [BV_W-1:0]      w_best_bv_n;
  logic [LIT_W-1:0]     w_best_lit_n;
  logic                 w_best_valid_n;

  break_popcount #(
    .NUM_CLAUSES (NUM_CLAUSES),
    .BV_W        (BV_W)
  ) u_popcount (
    .i_broken (eval_if.clause_broken_i),
    .i_mask   (eval_if.mask_bits_i),
    .o_count  (w_bv)
  );

  // A response only counts while a request is actually outstanding
  assign w_hs         = (r_state == S_REQ) && eval_if.eval_valid_i;
  assign w_better     = w_hs && (!r_best_valid || (w_bv < r_best_bv));
  assign w_lit_onehot = NUM_LITS'(1) << r_eval_lit;

`ifdef FREEBIE_EXIT_EN
  assign w_freebie = w_hs && (w_bv == '0);
`else
  assign w_freebie = 1'b0;
`endif

  // Best candidate including the response completing this cycle
  always_comb begin
    w_best_bv_n    = r_best_bv;
    w_best_lit_n   = r_best_lit;
    w_best_valid_n = r_best_valid;
    if (w_better) begin
      w_best_bv_n    = w_bv;
      w_best_lit_n   = r_eval_lit;
      w_best_valid_n = 1'b1;
    end
  end

  // Lowest-index pending slot
  always_comb begin
    w_first_lit = '0;
    for (int i = NUM_LITS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_first_lit = LIT_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start_i && !abort_i) w_state_next = S_FIND;
      S_FIND: w_state_next = (r_pend == '0) ? S_DONE : S_REQ;
      S_REQ:  if (w_hs) w_state_next = w_freebie ? S_DONE : S_FIND;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (abort_i && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end
  end

  // Scan datapath: pending mask, evaluated slot, running best, result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend       <= '0;
      r_eval_lit   <= '0;
      r_best_bv    <= c_bv_ones;
      r_best_lit   <= '0;
      r_best_valid <= 1'b0;
      r_sel_bv     <= c_bv_ones;
      r_sel_lit    <= '0;
      r_sel_valid  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_next == S_FIND)) begin
        r_pend       <= cand_valid_i;
        r_best_bv    <= c_bv_ones;
        r_best_lit   <= '0;
        r_best_valid <= 1'b0;
      end
      if ((r_state == S_FIND) && (w_state_next == S_REQ)) begin
        r_eval_lit <= w_first_lit;
      end
      if ((r_state == S_REQ) && w_hs && !abort_i) begin
        r_pend       <= r_pend & ~w_lit_onehot;
        r_best_bv    <= w_best_bv_n;
        r_best_lit   <= w_best_lit_n;
        r_best_valid <= w_best_valid_n;
      end
      if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
        r_sel_bv    <= w_best_bv_n;
        r_sel_lit   <= w_best_lit_n;
        r_sel_valid <= w_best_valid_n;
      end
    end
  end

  // Outputs decoded from the current state and result registers
  always_comb begin
    busy_o             = (r_state != S_IDLE);
    done_o             = (r_state == S_DONE);
    eval_if.eval_req_o = (r_state == S_REQ);
    eval_if.eval_lit_o = r_eval_lit;
    sel_valid_o        = r_sel_valid;
    sel_lit_o          = r_sel_lit;
    sel_break_o        = r_sel_bv;
  end

endmodule : break_scan_controller
`default_nettype wire

// File: tb/tb_break_scan_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_break_scan_controller
// Description : Self-checking bench for break_scan_controller. A scan-level
//               model predicts the request sequence, done cycle and winner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_break_scan_controller;

`ifdef FREEBIE_EXIT_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [2:0] cand = 3'b000;
  logic       busy_o, done_o, sel_valid_o;
  logic [1:0] sel_lit_o;
  logic [4:0] sel_break_o;

  break_scan_controller_if #(.NUM_CLAUSES(20), .NUM_LITS(3)) u_if ();

  break_scan_controller #(.NUM_CLAUSES(20), .NUM_LITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .cand_valid_i (cand),
    .eval_if      (u_if),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sel_valid_o  (sel_valid_o),
    .sel_lit_o    (sel_lit_o),
    .sel_break_o  (sel_break_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Evaluator stimulus
  logic [19:0] vec [4];
  logic [19:0] mask;
  int          dly [4];
  int          wait_cnt = 0;

  // Model state
  bit   active = 1'b0;
  bit   chk_en = 1'b0;
  int   t = 0;
  int   done_t = -1;
  int   end_t = 0;
  int   dn_t = -1;
  bit   e_req [64];
  int   e_lit [64];
  logic [2:0] req_seen;
  int   p_sv, p_sl, p_sb;
  int   m_sv = 0, m_sl = 0, m_sb = 31;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time=%0t)", name, act, exp, t, $time);
    end
  endtask

  // Cycle offset since the start pulse was sampled
  always @(posedge clk) if (active) t = t + 1;

  // Evaluator: answers after dly[slot] extra cycles; spurious valid while idle
  always @(negedge clk) begin
    if (u_if.eval_req_o) begin
      u_if.eval_valid_i = (wait_cnt >= dly[u_if.eval_lit_o]);
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      u_if.eval_valid_i = 1'b1;
    end
    u_if.clause_broken_i = vec[u_if.eval_lit_o];
    u_if.mask_bits_i     = mask;
  end

  // Per-cycle compare against the scan model
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_busy, exp_req, exp_done;
      if (active && t == done_t) begin
        m_sv = p_sv; m_sl = p_sl; m_sb = p_sb;
      end
      if (active && t >= 1 && t <= end_t) begin
        exp_busy = 1'b1; exp_req = e_req[t]; exp_done = (t == done_t);
      end else begin
        exp_busy = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
      end
      chk("busy", int'(busy_o), int'(exp_busy));
      chk("eval_req", int'(u_if.eval_req_o), int'(exp_req));
      if (exp_req) chk("eval_lit", int'(u_if.eval_lit_o), e_lit[t]);
      chk("done", int'(done_o), int'(exp_done));
      chk("sel_valid", int'(sel_valid_o), m_sv);
      chk("sel_lit", int'(sel_lit_o), m_sl);
      chk("sel_break", int'(sel_break_o), m_sb);
      if (active && u_if.eval_req_o) req_seen[u_if.eval_lit_o] = 1'b1;
      if (active && done_o && dn_t < 0) dn_t = t;
    end
  end

  // Build the expected timeline for one scan, then drive it
  task automatic scan(input logic [2:0] cv, input int abort_t, input bit poke);
    int cur, best_bv, best_lit, bv;
    bit bvalid, stop;
    for (int i = 0; i < 64; i++) begin e_req[i] = 1'b0; e_lit[i] = 0; end
    cur = 2; best_bv = 31; best_lit = 0; bvalid = 1'b0; stop = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (cv[s] && !stop) begin
        bv = $countones(vec[s] & mask);
        for (int d = 0; d <= dly[s]; d++) begin
          e_req[cur] = 1'b1; e_lit[cur] = s; cur++;
        end
        if (!bvalid || bv < best_bv) begin
          best_bv = bv; best_lit = s; bvalid = 1'b1;
        end
        if (FB && bv == 0) stop = 1'b1;
        else cur++;
      end
    end
    p_sv = int'(bvalid); p_sl = best_lit; p_sb = best_bv;
    if (abort_t > 0) begin
      end_t = abort_t; done_t = -1;
    end else begin
      done_t = cur; end_t = cur;
    end
    dn_t = -1; req_seen = 3'b000;
    @(negedge clk);
    cand = cv; start_i = 1'b1; t = 0; active = 1'b1;
    while (t <= end_t) begin
      @(negedge clk);
      start_i = poke && (t == 3 || t == 4);
      abort_i = (t == abort_t);
    end
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0; active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin vec[i] = '0; dly[i] = 0; end
    mask = 20'hFFFFF;
    u_if.eval_valid_i = 1'b0;
    u_if.clause_broken_i = '0;
    u_if.mask_bits_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_req", int'(u_if.eval_req_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_sel_valid", int'(sel_valid_o), 0);
    chk("rst_eval_lit", int'(u_if.eval_lit_o), 0);
    chk("rst_sel_lit", int'(sel_lit_o), 0);
    chk("rst_sel_break", int'(sel_break_o), 31);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Three slots, popcounts 4,2,5
    vec[0] = 20'h0000F; vec[1] = 20'h00300; vec[2] = 20'h1F000;
    scan(3'b111, 0, 1'b0);
    chk("t1_latency", dn_t, 8);
    chk("t1_reqs", int'(req_seen), 7);
    chk("t1_sel_lit", int'(sel_lit_o), 1);
    chk("t1_sel_break", int'(sel_break_o), 2);
    chk("t1_sel_valid", int'(sel_valid_o), 1);

    // Tie between slots 0 and 2
    vec[0] = 20'h00007; vec[1] = 20'h00000; vec[2] = 20'h70000;
    scan(3'b101, 0, 1'b0);
    chk("t2_reqs", int'(req_seen), 5);
    chk("t2_sel_lit", int'(sel_lit_o), 0);
    chk("t2_sel_break", int'(sel_break_o), 3);

    // No valid slots
    scan(3'b000, 0, 1'b0);
    chk("t3_latency", dn_t, 2);
    chk("t3_sel_valid", int'(sel_valid_o), 0);
    chk("t3_sel_break", int'(sel_break_o), 31);

    // All clauses broken, then fully masked
    vec[1] = 20'hFFFFF; mask = 20'hFFFFF;
    scan(3'b010, 0, 1'b0);
    chk("t4_all_broken", int'(sel_break_o), 20);
    chk("t4_sel_lit", int'(sel_lit_o), 1);
    mask = 20'h00000;
    scan(3'b010, 0, 1'b0);
    chk("t4_masked", int'(sel_break_o), 0);
    chk("t4_masked_latency", dn_t, FB ? 3 : 4);

    // Slow evaluator on slot 0 with stray start pulses
    mask = 20'hFFFFF;
    vec[0] = 20'h0000F; vec[1] = 20'h00300; dly[0] = 3;
    scan(3'b011, 0, 1'b1);
    chk("t5_latency", dn_t, 9);
    chk("t5_sel_lit", int'(sel_lit_o), 1);
    chk("t5_sel_break", int'(sel_break_o), 2);

    // Abort in REQ while the response arrives
    vec[0] = 20'h00000;
    scan(3'b011, 5, 1'b0);
    chk("t6_no_done", dn_t, -1);
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_sel_lit", int'(sel_lit_o), 1);
    chk("t6_sel_break", int'(sel_break_o), 2);
    dly[0] = 0;

    // Zero-break slot in the middle
    vec[0] = 20'h00003; vec[1] = 20'h00000; vec[2] = 20'h00100;
    scan(3'b111, 0, 1'b0);
    chk("t7_reqs", int'(req_seen), FB ? 3 : 7);
    chk("t7_sel_lit", int'(sel_lit_o), 1);
    chk("t7_sel_break", int'(sel_break_o), 0);
    chk("t7_latency", dn_t, FB ? 5 : 8);

    // Start together with abort in IDLE
    @(negedge clk);
    cand = 3'b111; start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("t8_no_scan", int'(busy_o), 0);

    // Asynchronous reset between clock edges
    chk_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t9_async_sel_valid", int'(sel_valid_o), 0);
    chk("t9_async_sel_break", int'(sel_break_o), 31);
    chk("t9_async_sel_lit", int'(sel_lit_o), 0);
    m_sv = 0; m_sl = 0; m_sb = 31;
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_break_scan_controller
`default_nettype wire

// File: doc/break_scan_controller.md
Name: break_scan_controller

Overview:
Sequences break-value evaluation for one WalkSAT flip decision. It walks the candidate literal slots of the selected unsatisfied clause and requests each slot's clause-broken vector from the clause evaluators. For each slot it counts the masked broken clauses and keeps the slot with the minimum break value. It sits between the clause-selection logic and the flip/heuristic stage, and reports one winning literal slot per scan.

Parameters:
NUM_CLAUSES, 20, clause vector width seen by the evaluators
NUM_LITS, 3, candidate literal slots per clause (one per clause-table row)
LIT_W (localparam), $clog2(NUM_LITS) with minimum 1, slot index width
BV_W (localparam), $clog2(NUM_CLAUSES+1), break-value width; must represent all-clauses-broken

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start_i  in  1  single-cycle pulse that begins a scan; honoured only in IDLE
abort_i  in  1  cancels any scan in progress
cand_valid_i  in  NUM_LITS  per-slot valid bits; sampled on accepted start_i
busy_o  out  1  high in every state except IDLE
eval_req_o  out  1  request to the evaluators to produce the broken vector for eval_lit_o
eval_lit_o  out  LIT_W  slot being evaluated
eval_valid_i  in  1  evaluator response valid; meaningful only while eval_req_o=1
clause_broken_i  in  NUM_CLAUSES  1 = clause broken if slot eval_lit_o is flipped
mask_bits_i  in  NUM_CLAUSES  clause-table valid mask
done_o  out  1  one-cycle pulse when the result is valid
sel_valid_o  out  1  at least one slot was evaluated
sel_lit_o  out  LIT_W  winning slot
sel_break_o  out  BV_W  break value of the winning slot

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - state=IDLE
  - busy_o, eval_req_o, done_o, sel_valid_o = 0
  - eval_lit_o, sel_lit_o = 0
  - sel_break_o = all ones
  - internal pending mask = 0
- States: IDLE, FIND, REQ, DONE.
- IDLE + start_i=1:
  - latch cand_valid_i into the pending mask.
  - clear the best register: best_bv = all ones, best_valid = 0.
  - go to FIND.
- FIND (one cycle):
  - If the pending mask is 0, go to DONE.
  - Otherwise set eval_lit_o to the lowest set pending index and go to REQ.
- REQ:
  - eval_req_o=1; eval_lit_o is held stable until the response arrives.
  - The evaluator may answer in the same cycle or any later cycle. The handshake completes on the first clk edge with eval_req_o=1 and eval_valid_i=1.
  - On completion:
    - bv = popcount(clause_broken_i & mask_bits_i), computed combinationally in BV_W bits with no truncation.
    - If best_valid=0 or bv < best_bv, update best_bv/best_lit/best_valid=1. Strictly-less comparison, so ties keep the lower slot index.
    - Clear the slot's pending bit and return to FIND; eval_req_o drops for that one cycle.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - sel_lit_o, sel_break_o and sel_valid_o are updated on DONE entry and hold until the next DONE or reset.
  - With no valid slots: sel_valid_o=0, sel_break_o=all ones, sel_lit_o=0.
- abort_i has priority over every other event in any non-IDLE state:
  - next state IDLE, no done_o, sel_* unchanged.
  - A response arriving in the same cycle is discarded.
- start_i outside IDLE is ignored. start_i and abort_i together in IDLE: abort wins, no scan starts.
- eval_valid_i while eval_req_o=0 is ignored.
- Latency with zero-wait evaluators = 2 + 2*N cycles from start_i to done_o, where N = number of valid slots. With N=0 it is 2 cycles.

Optional Feature:
FREEBIE_EXIT_EN
- Defined: when a completed response has bv==0, the controller goes directly to DONE with that slot, skipping the remaining pending slots.
- Undefined: every valid slot is always evaluated; the zero-break result is still selected by the normal compare.

Decomposition:
- Shared package sat_pkg:
  - state enum {IDLE, FIND, REQ, DONE}
  - helper function for BV_W
  - all-ones break-value constant
- One sub-module: break_popcount, a combinational masked popcount with parameter NUM_CLAUSES and output width BV_W (must not truncate at all-broken).
- Priority-encode and compare logic stay inline.

Test Plan:
- cand_valid=3'b111, zero-wait evaluator returning popcounts 4,2,5 → eval_lit 0,1,2 in order; done_o at cycle 8; sel_lit=1, sel_break=2, sel_valid=1.
- cand_valid=3'b101, popcounts 3,3 → slot 1 never requested; sel_lit=0 (tie keeps lower index), sel_break=3.
- cand_valid=3'b000 → done_o 2 cycles after start_i; sel_valid=0, sel_break=all ones.
- NUM_CLAUSES=20, all 20 bits broken, mask all ones on one slot → sel_break=20 with no wrap. Mask=0 on the same vector → sel_break=0.
- Evaluator delays valid by 3 cycles on slot 0 → eval_req_o and eval_lit_o held stable; start_i pulses mid-scan are ignored. Assert abort_i during REQ → IDLE next cycle, no done_o, sel_* unchanged.
- FREEBIE_EXIT_EN defined, popcounts 2,0,1 → slot 2 never requested; sel_lit=1, sel_break=0. Undefined → all three slots requested, same result.
